// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiplier and restoring divider share one hi/lo datapath.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic             neg_a;
  logic             neg_b;
  logic             b_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;

  logic             sgn_a;
  logic             sgn_b;
  logic             in_neg_a;
  logic             in_neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (op)
      3'b000,
      3'b001,
      3'b100,
      3'b110: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      3'b010: sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign in_neg_a = sgn_a & operand_a[WIDTH-1];
  assign in_neg_b = sgn_b & operand_b[WIDTH-1];
  assign abs_a    = in_neg_a ? -operand_a : operand_a;
  assign abs_b    = in_neg_b ? -operand_b : operand_b;

  logic             is_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_tr;
  logic             div_ok;

  assign is_div  = op_q[2];
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  assign div_sh  = {hi, lo[WIDTH-1]};
  assign div_tr  = div_sh - {1'b0, m};
  assign div_ok  = ~div_tr[WIDTH];

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_val;

  // A zero divisor leaves hi = |a|, so the remainder sign fix restores a.
  assign prod   = {hi, lo};
  assign prod_s = (neg_a ^ neg_b) ? -prod : prod;
  assign quo    = b_zero ? '1 : ((neg_a ^ neg_b) ? -lo : lo);
  assign rem    = neg_a ? -hi : hi;

  always_comb begin
    fix_val = prod_s[WIDTH-1:0];
    unique case (op_q)
      3'b000:  fix_val = prod_s[WIDTH-1:0];
      3'b001,
      3'b010,
      3'b011:  fix_val = prod_s[2*WIDTH-1:WIDTH];
      3'b100,
      3'b101:  fix_val = quo;
      default: fix_val = rem;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= CALC;
            cnt    <= '0;
            busy   <= 1'b1;
            op_q   <= op;
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            b_zero <= (operand_b == '0);
            hi     <= '0;
            lo     <= op[2] ? abs_a : abs_b;
            m      <= op[2] ? abs_b : abs_a;
          end
        end
        CALC: begin
          if (is_div) begin
            hi <= div_ok ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], div_ok};
          end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= fix_val;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit.
// Expected values come from plain 64-bit / int arithmetic.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clock = ~clock;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(logic [2:0] f,
                                        logic [31:0] a,
                                        logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib, q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = ia / ib;
        return q;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        q = ia % ib;
        return q;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Drives start for one edge; returns at the negedge after acceptance.
  task automatic issue(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    @(negedge clock);
    start     = 1'b1;
    op        = f;
    operand_a = a;
    operand_b = b;
    @(posedge clock);
    @(negedge clock);
    start     = 1'b0;
    op        = 3'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  // Counts edges until done is seen; busy must stay high until then.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clock);
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run(string tag, logic [2:0] f,
                     logic [31:0] a, logic [31:0] b);
    int lat;
    bit bok;
    issue(f, a, b);
    wait_done(lat, bok);
    check({tag, "_lat"}, lat, 33);
    check({tag, "_busy"}, bok, 1);
    check({tag, "_busy_done"}, busy, 0);
    check(tag, result, model(f, a, b));
  endtask

  initial begin
    int lat;
    bit bok;
    bit quiet;
    reset     = 1'b1;
    start     = 1'b0;
    op        = '0;
    operand_a = '0;
    operand_b = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);

    run("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul_7_m3_abs", result, 32'hFFFF_FFEB);
    @(negedge clock);
    check("done_pulse", done, 0);
    check("result_hold", result, 32'hFFFF_FFEB);

    run("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
    check("mulh_abs", result, 32'h4000_0000);
    run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_abs", result, 32'hFFFF_FFFE);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhsu_abs", result, 32'hFFFF_FFFF);
    run("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_abs", result, 32'hFFFF_FFFD);
    run("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    check("rem_m7_2_abs", result, 32'hFFFF_FFFF);
    run("divu", 3'd5, 32'd100, 32'd7);
    check("divu_abs", result, 32'd14);
    run("remu", 3'd7, 32'd100, 32'd7);
    check("remu_abs", result, 32'd2);
    run("div0", 3'd4, 32'd5, 32'd0);
    check("div0_abs", result, 32'hFFFF_FFFF);
    run("remu0", 3'd7, 32'd5, 32'd0);
    check("remu0_abs", result, 32'd5);
    run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_abs", result, 32'h8000_0000);
    run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    check("rem_ovf_abs", result, 32'd0);
    run("rem_neg0", 3'd6, 32'hFFFF_FFF9, 32'd0);
    run("div_neg0", 3'd4, 32'hFFFF_FFF9, 32'd0);

    // Start while busy is dropped; start in the done cycle is taken.
    issue(3'd5, 32'd100, 32'd7);
    repeat (4) @(negedge clock);
    start     = 1'b1;
    op        = 3'd0;
    operand_a = 32'd3;
    operand_b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    wait_done(lat, bok);
    check("ign_lat", lat + 5, 33);
    check("ign_result", result, 32'd14);
    start     = 1'b1;
    op        = 3'd0;
    operand_a = 32'd3;
    operand_b = 32'd3;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done_low", done, 0);
    wait_done(lat, bok);
    check("b2b_lat", lat, 33);
    check("b2b_result", result, 32'd9);

    // Reset mid-operation aborts without a done pulse.
    issue(3'd0, 32'd6, 32'd7);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("abort_quiet", quiet, 1);
    check("abort_result_hold", result, 0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run($sformatf("rnd%0d_op%0d", i, f), f, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file: consumes the two register read ports (rs1/rs2 data) and produces the value driven onto the register file write-data path for M-extension instructions.
- Control logic stalls the core while busy is high and writes result back when done pulses.
- Fixed-latency radix-2 shift-add multiplier and restoring divider sharing one datapath.

Parameters:
WIDTH, 32, operand/result width in bits; latency scales as WIDTH+1; only 32 is required to be verified.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset, sampled on rising edge of clock
start  input  1  request; accepted only when busy=0
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  input  WIDTH  rs1 value (register file read port 1)
operand_b  input  WIDTH  rs2 value (register file read port 2)
busy  output  1  operation in progress; inputs ignored
done  output  1  one-cycle pulse; result valid from this cycle
result  output  WIDTH  final result, held until next accepted operation completes or reset

Behaviour:
- Reset: synchronous, active-high, takes effect at the clock edge. Sets state=IDLE, busy=0, done=0, result=0, internal registers cleared. Reset mid-operation aborts the operation: no done pulse and no result update.
- States:
  - IDLE: busy=0.
  - CALC: busy=1, iteration counter 0..WIDTH-1.
  - FIX: busy=1, one cycle for sign correction and result load.
- IDLE to CALC at edge E0 when start=1. At E0 latch op, operand_a, operand_b, absolute values, and sign flags.
  - Signed: MULH both operands; MULHSU operand_a only; DIV/REM both operands.
  - Unsigned: MULHU, DIVU, REMU use raw values.
- CALC: one iteration per edge, E1..EWIDTH. Counter reaches WIDTH-1, then FIX.
- FIX to IDLE at edge EWIDTH+1: result registered, done=1 for exactly that cycle, busy=0 in the same cycle.
  - For WIDTH=32, done is observed 33 cycles after the start edge.
- Latency is fixed for all ops and operands, including special cases. There is no early-out.
- Multiply: 2*WIDTH-bit unsigned product of magnitudes, negated if signs differ.
  - MUL returns low WIDTH bits.
  - MULH/MULHSU/MULHU return high WIDTH bits.
- Divide: restoring division of magnitudes. Quotient negated if signs differ; remainder takes the sign of the dividend.
- Divide by zero (operand_b=0): quotient = all ones; remainder = operand_a unmodified. Applies to signed and unsigned.
- Signed overflow (DIV/REM with operand_a = 0x80000000 and operand_b = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- start while busy=1: ignored, no queueing. Inputs are not required to be stable after the accepting edge.
- start=1 in the done cycle: accepted, because state is IDLE. Back-to-back throughput is one op per WIDTH+1 cycles.
- result changes only at the FIX edge or on reset. done never asserts without a preceding accepted start.
- op, operand_a, and operand_b may be X while start=0.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3): start at edge E0 → done=1 after E33, result=0xFFFFFFEB; busy=1 for E0..E32.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Corner cases, each at 33-cycle latency:
  - DIV 5/0 → 0xFFFFFFFF
  - REMU 5/0 → 5
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000
  - REM same operands → 0
- Start DIVU 100/7; pulse start with MUL 3×3 at cycle 5 → ignored, result=14. Start MUL 3×3 in the done cycle → accepted, result=9 after 33 cycles.
- Start MUL 6×7; assert reset at cycle 10 → busy=0 and result=0 after that edge; done stays 0 for the next 40 cycles.
